// File: rtl/ycbcr_skin_bbox_pkg.sv
// Shared constants for the YCbCr skin classifier and bounding-box tracker.
package ycbcr_pkg;

  localparam logic [7:0] CB_MIN_DEF = 8'd77;
  localparam logic [7:0] CB_MAX_DEF = 8'd127;
  localparam logic [7:0] CR_MIN_DEF = 8'd133;
  localparam logic [7:0] CR_MAX_DEF = 8'd173;

  localparam int unsigned COORD_W_DEF = 11;
  localparam int unsigned CNT_W_DEF   = 21;
  localparam int unsigned MIN_PIX_DEF = 64;

  localparam logic [7:0] SKIN_ON  = 8'hFF;
  localparam logic [7:0] SKIN_OFF = 8'h00;

  // A latch before the first frame start only covers a partial frame.
  typedef enum logic {
    BOX_UNARMED = 1'b0,
    BOX_ARMED   = 1'b1
  } arm_state_e;

  function automatic logic in_window(input logic [7:0] v,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ycbcr_skin_bbox_if.sv
// Incoming YCbCr 4:4:4 pixel stream with its video timing signals.
interface ycbcr_skin_bbox_if;

  logic       pre_frame_vsync;
  logic       pre_frame_hsync;
  logic       pre_frame_de;
  logic [7:0] img_y;
  logic [7:0] img_cb;
  logic [7:0] img_cr;

  modport master (
    output pre_frame_vsync, pre_frame_hsync, pre_frame_de,
    output img_y, img_cb, img_cr
  );

  modport slave (
    input pre_frame_vsync, pre_frame_hsync, pre_frame_de,
    input img_y, img_cb, img_cr
  );

endinterface

// File: rtl/ycbcr_skin_bbox_accum.sv
// Pixel coordinate counters, per-frame skin bounding-box accumulation and
// the frame-start latch of the box registers.
module skin_bbox_accum
  import ycbcr_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MIN_PIX = MIN_PIX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               de,
  input  logic               skin,
  output logic [COORD_W-1:0] box_x_min,
  output logic [COORD_W-1:0] box_x_max,
  output logic [COORD_W-1:0] box_y_min,
  output logic [COORD_W-1:0] box_y_max,
  output logic [CNT_W-1:0]   box_count,
  output logic               box_valid,
  output logic               frame_done
);

  localparam logic [COORD_W-1:0] COORD_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic               vsync_d1;
  logic               de_d1;
  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;
  logic [COORD_W-1:0] acc_x_min;
  logic [COORD_W-1:0] acc_x_max;
  logic [COORD_W-1:0] acc_y_min;
  logic [COORD_W-1:0] acc_y_max;
  logic [CNT_W-1:0]   acc_cnt;
  arm_state_e         arm;

  logic frame_start;
  logic line_end;
  logic latch_valid;

  always_comb begin
    frame_start = vsync & ~vsync_d1;
    line_end    = de_d1 & ~de;
    latch_valid = (arm == BOX_ARMED) && (acc_cnt >= CNT_W'(MIN_PIX));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d1   <= 1'b0;
      de_d1      <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      acc_x_min  <= '1;
      acc_x_max  <= '0;
      acc_y_min  <= '1;
      acc_y_max  <= '0;
      acc_cnt    <= '0;
      arm        <= BOX_UNARMED;
      box_x_min  <= '0;
      box_x_max  <= '0;
      box_y_min  <= '0;
      box_y_max  <= '0;
      box_count  <= '0;
      box_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vsync_d1   <= vsync;
      de_d1      <= de;
      frame_done <= frame_start;

      if (de) begin
        if (x_cnt != COORD_MAX) x_cnt <= x_cnt + COORD_W'(1);
      end else begin
        x_cnt <= '0;
      end

      if (frame_start) begin
        y_cnt <= '0;
      end else if (line_end && (y_cnt != COORD_MAX)) begin
        y_cnt <= y_cnt + COORD_W'(1);
      end

      if (frame_start) begin
        box_x_min <= latch_valid ? acc_x_min : '0;
        box_x_max <= latch_valid ? acc_x_max : '0;
        box_y_min <= latch_valid ? acc_y_min : '0;
        box_y_max <= latch_valid ? acc_y_max : '0;
        box_count <= acc_cnt;
        box_valid <= latch_valid;
        arm       <= BOX_ARMED;
        // A pixel coincident with frame start seeds the new frame at row 0.
        acc_x_min <= skin ? x_cnt : '1;
        acc_x_max <= skin ? x_cnt : '0;
        acc_y_min <= '1;
        acc_y_max <= '0;
        if (skin) acc_y_min <= '0;
        acc_cnt   <= skin ? CNT_W'(1) : '0;
      end else if (skin) begin
        if (x_cnt < acc_x_min) acc_x_min <= x_cnt;
        if (x_cnt > acc_x_max) acc_x_max <= x_cnt;
        if (y_cnt < acc_y_min) acc_y_min <= y_cnt;
        if (y_cnt > acc_y_max) acc_y_max <= y_cnt;
        if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ycbcr_skin_bbox.sv
// Cb/Cr window skin classifier producing a binary mask stream with 1-cycle
// latency, plus per-frame skin bounding box from skin_bbox_accum.
module ycbcr_skin_bbox
  import ycbcr_pkg::*;
#(
  parameter logic [7:0]  CB_MIN  = CB_MIN_DEF,
  parameter logic [7:0]  CB_MAX  = CB_MAX_DEF,
  parameter logic [7:0]  CR_MIN  = CR_MIN_DEF,
  parameter logic [7:0]  CR_MAX  = CR_MAX_DEF,
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MIN_PIX = MIN_PIX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  ycbcr_skin_bbox_if.slave   pre,
  output logic               post_frame_vsync,
  output logic               post_frame_hsync,
  output logic               post_frame_de,
  output logic [7:0]         img_bin,
  output logic [COORD_W-1:0] box_x_min,
  output logic [COORD_W-1:0] box_x_max,
  output logic [COORD_W-1:0] box_y_min,
  output logic [COORD_W-1:0] box_y_max,
  output logic [CNT_W-1:0]   box_count,
  output logic               box_valid,
  output logic               frame_done
);

  logic skin;
  logic unused_luma;

  always_comb begin
    skin = pre.pre_frame_de
         && in_window(pre.img_cb, CB_MIN, CB_MAX)
         && in_window(pre.img_cr, CR_MIN, CR_MAX);
  end

  // Luma is part of the incoming bus but plays no role in classification.
  assign unused_luma = ^pre.img_y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_hsync <= 1'b0;
      post_frame_de    <= 1'b0;
      img_bin          <= SKIN_OFF;
    end else begin
      post_frame_vsync <= pre.pre_frame_vsync;
      post_frame_hsync <= pre.pre_frame_hsync;
      post_frame_de    <= pre.pre_frame_de;
      img_bin          <= skin ? SKIN_ON : SKIN_OFF;
    end
  end

  skin_bbox_accum #(
    .COORD_W (COORD_W),
    .CNT_W   (CNT_W),
    .MIN_PIX (MIN_PIX)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (pre.pre_frame_vsync),
    .de         (pre.pre_frame_de),
    .skin       (skin),
    .box_x_min  (box_x_min),
    .box_x_max  (box_x_max),
    .box_y_min  (box_y_min),
    .box_y_max  (box_y_max),
    .box_count  (box_count),
    .box_valid  (box_valid),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_ycbcr_skin_bbox.sv
// Randomised bench for ycbcr_skin_bbox against a frame-level reference model.
module tb_ycbcr_skin_bbox;
  import ycbcr_pkg::*;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned CNT_W   = 21;
  localparam int unsigned MIN_PIX = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               post_frame_vsync, post_frame_hsync, post_frame_de;
  logic [7:0]         img_bin;
  logic [COORD_W-1:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic [CNT_W-1:0]   box_count;
  logic               box_valid, frame_done;

  ycbcr_skin_bbox_if vif();

  ycbcr_skin_bbox #(
    .CB_MIN  (8'd77),
    .CB_MAX  (8'd127),
    .CR_MIN  (8'd133),
    .CR_MAX  (8'd173),
    .COORD_W (COORD_W),
    .CNT_W   (CNT_W),
    .MIN_PIX (MIN_PIX)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pre              (vif),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_hsync (post_frame_hsync),
    .post_frame_de    (post_frame_de),
    .img_bin          (img_bin),
    .box_x_min        (box_x_min),
    .box_x_max        (box_x_max),
    .box_y_min        (box_y_min),
    .box_y_max        (box_y_max),
    .box_count        (box_count),
    .box_valid        (box_valid),
    .frame_done       (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: skin pixels of the current frame are collected as (x,y)
  // pairs and reduced to a box only when the frame closes.
  typedef struct { int x; int y; } pix_t;
  pix_t q[$];
  bit m_vprev, m_deprev, m_armed;
  int m_col, m_row;
  int e_vs, e_hs, e_de, e_bin, e_done;
  int e_xmin, e_xmax, e_ymin, e_ymax, e_cnt, e_valid;

  function automatic bit is_skin(input bit de, input int cb, input int cr);
    return de && cb >= 77 && cb <= 127 && cr >= 133 && cr <= 173;
  endfunction

  task automatic model_reset();
    {e_vs, e_hs, e_de, e_bin, e_done} = '0;
    e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cnt = 0; e_valid = 0;
    m_vprev = 0; m_deprev = 0; m_armed = 0; m_col = 0; m_row = 0;
    q.delete();
  endtask

  task automatic model_latch();
    int n;
    n = q.size();
    e_cnt   = n;
    e_valid = (m_armed && n >= MIN_PIX) ? 1 : 0;
    e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
    if (e_valid != 0) begin
      e_xmin = 2047; e_ymin = 2047;
      foreach (q[i]) begin
        if (q[i].x < e_xmin) e_xmin = q[i].x;
        if (q[i].x > e_xmax) e_xmax = q[i].x;
        if (q[i].y < e_ymin) e_ymin = q[i].y;
        if (q[i].y > e_ymax) e_ymax = q[i].y;
      end
    end
  endtask

  task automatic model_step(input bit v, input bit h, input bit de, input int cb, input int cr);
    bit fs, sk;
    pix_t p;
    fs = v && !m_vprev;
    sk = is_skin(de, cb, cr);
    e_vs = v; e_hs = h; e_de = de;
    e_bin  = sk ? 255 : 0;
    e_done = fs;
    if (fs) begin
      model_latch();
      q.delete();
      m_armed = 1;
    end
    if (sk) begin
      p.x = m_col;
      p.y = fs ? 0 : m_row;
      q.push_back(p);
    end
    if (fs) m_row = 0;
    else if (m_deprev && !de && m_row < 2047) m_row++;
    if (de) begin
      if (m_col < 2047) m_col++;
    end else begin
      m_col = 0;
    end
    m_vprev = v; m_deprev = de;
  endtask

  task automatic cyc(input bit rst, input bit v, input bit h, input bit de, input int cb, input int cr);
    rst_n = ~rst;
    vif.pre_frame_vsync = v;
    vif.pre_frame_hsync = h;
    vif.pre_frame_de    = de;
    vif.img_y  = 8'($urandom);
    vif.img_cb = 8'(cb);
    vif.img_cr = 8'(cr);
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step(v, h, de, cb, cr);
    check("post_vsync", 32'(post_frame_vsync), 32'(e_vs));
    check("post_hsync", 32'(post_frame_hsync), 32'(e_hs));
    check("post_de",    32'(post_frame_de),    32'(e_de));
    check("img_bin",    32'(img_bin),          32'(e_bin));
    check("frame_done", 32'(frame_done),       32'(e_done));
    check("box_x_min",  32'(box_x_min),        32'(e_xmin));
    check("box_x_max",  32'(box_x_max),        32'(e_xmax));
    check("box_y_min",  32'(box_y_min),        32'(e_ymin));
    check("box_y_max",  32'(box_y_max),        32'(e_ymax));
    check("box_count",  32'(box_count),        32'(e_cnt));
    check("box_valid",  32'(box_valid),        32'(e_valid));
  endtask

  task automatic pick(input int mode, input int x, input int y, output int cb, output int cr);
    cr = 150;
    case (mode)
      0: cb = 100;
      1: cb = (y == 2 && x >= 3 && x <= 5) ? 100 : 50;
      2: cb = 50;
      4: cb = (y == 1 && x < 2) ? 100 : 50;
      default: begin
        cb = 60 + int'($urandom_range(0, 80));
        cr = 120 + int'($urandom_range(0, 60));
      end
    endcase
  endtask

  task automatic frame(input int w, input int h, input int mode, input int vs_len);
    int cb, cr;
    for (int i = 0; i < vs_len; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 100, 150);
    for (int y = 0; y < h; y++) begin
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      for (int x = 0; x < w; x++) begin
        pick(mode, x, y, cb, cr);
        cyc(0, 0, 0, 1, cb, cr);
      end
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end
  endtask

  int bnd_cb[10] = '{77, 127, 100, 100, 76, 128, 100, 100, 77, 127};
  int bnd_cr[10] = '{150, 150, 133, 173, 150, 150, 132, 174, 133, 173};

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);

    frame(8, 4, 0, 3);                 // first latch is unarmed
    frame(8, 4, 0, 3);                 // latches the first full-skin frame
    frame(8, 4, 1, 2);                 // latches second full frame
    frame(8, 4, 4, 2);                 // latches 3-pixel strip, count == MIN_PIX
    frame(6, 3, 2, 2);                 // latches 2-pixel frame, below MIN_PIX

    // Boundary Cb/Cr classifications on one line, plus skin values with de low.
    frame(0, 0, 2, 2);                 // latches zero-skin frame
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, bnd_cb[i], bnd_cr[i]);
    cyc(0, 0, 0, 0, 100, 150);
    cyc(0, 0, 0, 0, 100, 150);

    // Skin pixel coincident with the vsync rising edge, then a long vsync
    // carrying active pixels.
    cyc(0, 1, 0, 1, 100, 150);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 100, 150);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 110, 140);
    cyc(0, 0, 0, 0, 0, 0);

    for (int f = 0; f < 5; f++)
      frame(int'($urandom_range(4, 12)), int'($urandom_range(2, 6)), 3,
            int'($urandom_range(1, 6)));

    // Reset in the middle of a frame.
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 100, 150);
    cyc(1, 0, 0, 1, 100, 150);
    cyc(1, 0, 0, 0, 0, 0);
    frame(4, 3, 0, 2);                 // latches post-reset partial frame
    frame(5, 4, 3, 2);
    frame(7, 3, 0, 3);
    frame(0, 0, 0, 2);                 // closes the last frame
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ycbcr_skin_bbox.md
Name: ycbcr_skin_bbox

Overview:
Consumes the YCbCr 4:4:4 pixel stream and its delayed vsync/hsync/de from the RGB-to-YCbCr stage. Each pixel is classified as skin or non-skin by Cb/Cr window thresholds, and the block emits an 8-bit binary mask stream with aligned syncs. In parallel it accumulates a per-frame bounding box and pixel count of skin pixels, latched at each frame start for the overlay/gesture logic downstream.

Parameters:
CB_MIN, 77, inclusive lower Cb bound for skin
CB_MAX, 127, inclusive upper Cb bound
CR_MIN, 133, inclusive lower Cr bound
CR_MAX, 173, inclusive upper Cr bound
COORD_W, 11, width of x/y coordinate counters (max 2047)
CNT_W, 21, width of skin pixel counter
MIN_PIX, 64, minimum skin pixels for a valid box

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, synchronous, active-low
pre_frame_vsync  in  1  vsync, active-high
pre_frame_hsync  in  1  hsync, passed through
pre_frame_de  in  1  pixel valid
img_y  in  8  luma (unused for classification, not forwarded)
img_cb  in  8  Cb
img_cr  in  8  Cr
post_frame_vsync  out  1  vsync delayed 1 cycle
post_frame_hsync  out  1  hsync delayed 1 cycle
post_frame_de  out  1  de delayed 1 cycle
img_bin  out  8  0xFF skin, 0x00 otherwise; 0x00 when post_frame_de low
box_x_min, box_x_max  out  COORD_W  latched box columns
box_y_min, box_y_max  out  COORD_W  latched box rows
box_count  out  CNT_W  latched skin pixel count (saturating)
box_valid  out  1  level: latched frame had count >= MIN_PIX and was a complete frame
frame_done  out  1  1-cycle pulse when box_* update

Behaviour:
- Reset (rst_n low at clk edge): all outputs 0; x_cnt, y_cnt, accumulators, vsync_d cleared; armed flag cleared.
- skin = de & (CB_MIN<=cb<=CB_MAX) & (CR_MIN<=cr<=CR_MAX), unsigned compares, bounds inclusive.
- Stream path: exactly 1 cycle latency; img_bin, post_* registered from the same input cycle.
- x_cnt: increments on each de cycle, saturates at 2^COORD_W-1; cleared on the first cycle de is low. Pixel x coordinate = x_cnt value before increment (first pixel of line = 0).
- y_cnt: increments on de falling edge (de_d1 & ~de); saturates at 2^COORD_W-1; cleared on frame_start.
- frame_start = vsync & ~vsync_d1 (rising edge of input vsync).
- Accumulators: xmin/ymin reset to all-ones, xmax/ymax to 0, cnt to 0. For each skin pixel: min/max updated with its (x, y); cnt += 1, saturating.
- On a frame_start edge:
  - box_x/y_min/max and box_count load accumulator values.
  - box_valid = armed & (cnt >= MIN_PIX).
  - If box_valid would be 0, all box coords load 0; box_count still loads.
  - Accumulators re-initialise; armed set to 1.
  - frame_done pulses 1 on the following cycle only.
- armed: ensures a partial frame after reset never produces box_valid=1. The first frame_start after reset only arms.
- Simultaneous de and frame_start: pixel belongs to the new frame. The accumulator reloads with that pixel's contribution, with y = 0.
- vsync held high for many cycles: only one frame_start.
- de during vsync high: processed normally.
- Box outputs stable between frame_done pulses.

Decomposition:
- Shared package ycbcr_pkg: default CB/CR bounds, COORD_W, CNT_W, and the mask constants SKIN_ON=8'hFF, SKIN_OFF=8'h00.
- One sub-module, skin_bbox_accum: x/y counters, min/max/count accumulators, latch and frame_done logic.
- The top level keeps the classifier and the 1-cycle stream delay.

Test Plan:
- Reset then two 8x4 frames, all pixels cb=100, cr=150, MIN_PIX=16 -> first frame_start: box_valid=0 (unarmed); second: box 0..7 x 0..3, box_count=32, box_valid=1, frame_done single pulse.
- Frame with skin only at (x=3..5, y=2), others cb=50 -> box_count=3, with MIN_PIX=2: x_min=3, x_max=5, y_min=y_max=2, valid=1.
- Boundary values cb=77/127, cr=133/173 -> img_bin=0xFF; cb=76, cb=128, cr=132, cr=174 -> 0x00; output 1 cycle after input, post_* equally delayed.
- Zero-skin frame -> box_count=0, box_valid=0, all coords 0.
- de high in frame_start cycle with skin pixel -> next latched frame includes it at (0,0), count incremented.
- rst_n pulsed mid-frame -> outputs 0 next cycle; next frame_start gives box_valid=0; the following gives a valid box.
